// File: rtl/jk_pkg.sv
// Shared types for the JK bank driver.
// State encoding and J/K pair constants.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK
  } state_t;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation mapper.
// Maps current/next Q and toggle mode to a J/K pair.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q_cur,
  input  logic q_next,
  input  logic toggle,
  output logic j,
  output logic k
);

  logic       chg;
  logic [1:0] pair;

  assign chg = q_cur ^ q_next;

  // pick the excitation pair for this bit
  always_comb begin
    pair = JK_HOLD;
    unique case (1'b1)
      (!chg):                     pair = JK_HOLD;
      (chg && toggle):            pair = JK_TOGGLE;
      (chg && !toggle && q_next): pair = JK_SET;
      default:                    pair = JK_RESET;
    endcase
  end

  assign j = pair[1];
  assign k = pair[0];

endmodule

// File: rtl/jk_bank_driver.sv
// Drives J/K vectors that move a JK bank to a target word.
// Optional feedback check: define JK_FB_CHECK_EN.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_toggle,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] shadow_q,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] HOLD_LAST =
    (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
  localparam bit HAS_WAIT = (HOLD_CYCLES > 0);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite_bit u_bit (
      .q_cur  (shadow_q[i]),
      .q_next (tgt_data[i]),
      .toggle (tgt_toggle),
      .j      (exc_j[i]),
      .k      (exc_k[i])
    );
  end

  assign tgt_ready = (state == IDLE);

  // state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and accept decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tgt_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        state_nxt = HAS_WAIT ? WAIT : CHECK;
      end
      WAIT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // excitation, shadow copy, settle counter and done
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      j        <= '0;
      k        <= '0;
      target   <= '0;
      shadow_q <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state_nxt == CHECK);
      if (accept) begin
        j      <= exc_j;
        k      <= exc_k;
        target <= tgt_data;
      end else begin
        j <= '0;
        k <= '0;
      end
      if (state == DRIVE) begin
        shadow_q <= target;
      end
      if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef JK_FB_CHECK_EN
  // sticky mismatch between bank feedback and shadow
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err <= 1'b0;
    end else if (state == CHECK && q_fb != shadow_q) begin
      err <= 1'b1;
    end
  end
`else
  // q_fb has no effect in this build
  assign err = &{1'b0, ^q_fb};
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Randomized bench for jk_bank_driver.
// Models the JK bank and expected behaviour.
module tb_jk_bank_driver;

  localparam int W    = 8;
  localparam int HOLD = 1;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt_data;
  logic         tgt_toggle;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q_fb;
  logic [W-1:0] shadow_q;
  logic         done;
  logic         err;

  logic [W-1:0] bank;
  logic         fault;
  logic [W-1:0] exp_sh;
  logic         exp_err;
  int           n_checks;
  int           n_errors;

  jk_bank_driver #(
    .WIDTH       (W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_data   (tgt_data),
    .tgt_toggle (tgt_toggle),
    .j          (j),
    .k          (k),
    .q_fb       (q_fb),
    .shadow_q   (shadow_q),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // JK characteristic equation: Q+ = J&~Q | ~K&Q
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) bank <= '0;
    else bank <= (j & ~bank) | (~k & bank);
  end

  assign q_fb = bank ^ (fault ? 8'h08 : 8'h00);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // one full update; caller is at a negedge with DUT idle
  task automatic do_word(input logic [W-1:0] t,
                         input logic tog,
                         input logic inject);
    logic [W-1:0] s;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    s  = exp_sh;
    ej = tog ? (s ^ t) : (t & ~s);
    ek = tog ? (s ^ t) : (s & ~t);
    check("ready_idle", 32'(tgt_ready), 32'd1);
    tgt_valid  = 1'b1;
    tgt_data   = t;
    tgt_toggle = tog;
    @(posedge clk);
    @(negedge clk);
    tgt_data   = W'($urandom);
    tgt_toggle = 1'($urandom);
    check("drive_j", 32'(j), 32'(ej));
    check("drive_k", 32'(k), 32'(ek));
    check("drive_ready", 32'(tgt_ready), 32'd0);
    check("drive_done", 32'(done), 32'd0);
    check("drive_shadow", 32'(shadow_q), 32'(s));
    for (int h = 0; h < HOLD; h++) begin
      @(negedge clk);
      tgt_data = W'($urandom);
      check("wait_jk", 32'({j, k}), 32'd0);
      check("wait_shadow", 32'(shadow_q), 32'(t));
      check("wait_bank", 32'(bank), 32'(t));
      check("wait_ready", 32'(tgt_ready), 32'd0);
      check("wait_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("chk_done", 32'(done), 32'd1);
    check("chk_ready", 32'(tgt_ready), 32'd0);
    check("chk_shadow", 32'(shadow_q), 32'(t));
    check("chk_jk", 32'({j, k}), 32'd0);
    fault     = inject;
    tgt_valid = 1'b0;
    @(negedge clk);
    fault = 1'b0;
`ifdef JK_FB_CHECK_EN
    if (inject) exp_err = 1'b1;
`endif
    exp_sh = t;
    check("post_done", 32'(done), 32'd0);
    check("post_ready", 32'(tgt_ready), 32'd1);
    check("post_bank", 32'(bank), 32'(t));
    check("post_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    fault      = 1'b0;
    exp_sh     = '0;
    exp_err    = 1'b0;
    clr_n      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_data   = '0;
    tgt_toggle = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_jk", 32'({j, k}), 32'd0);
    check("rst_shadow", 32'(shadow_q), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    clr_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(tgt_ready), 32'd1);

    do_word(8'hA5, 1'b0, 1'b0);
    do_word(8'h5A, 1'b1, 1'b0);
    do_word(8'h0F, 1'b0, 1'b0);
    do_word(8'h0F, 1'b0, 1'b0);
    do_word(8'h3C, 1'b0, 1'b1);
    do_word(8'hC3, 1'b1, 1'b0);
    for (int n = 0; n < 24; n++) begin
      do_word(W'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset while in DRIVE
    tgt_valid  = 1'b1;
    tgt_data   = ~exp_sh;
    tgt_toggle = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_jk", 32'(|{j, k}), 32'd1);
    clr_n     = 1'b0;
    tgt_valid = 1'b0;
    #1;
    check("mid_rst_j", 32'(j), 32'd0);
    check("mid_rst_k", 32'(k), 32'd0);
    check("mid_rst_shadow", 32'(shadow_q), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    exp_sh  = '0;
    exp_err = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rel_ready", 32'(tgt_ready), 32'd1);
      check("rel_done", 32'(done), 32'd0);
    end
    do_word(8'h81, 1'b1, 1'b0);
    do_word(W'($urandom), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
